// File: rtl/pid_controller_mc.sv
// Multi-channel, time-multiplexed fixed-point PID controller.
// One shared multiplier walks every channel through P, I, D and SUM steps.
module pid_controller_mc #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 9,
   parameter int K_INT  = 8,
   parameter int K_FRAC = 8,
   parameter int ACC_W  = 32,
   parameter int OUT_W  = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 sample_en,
   input  logic                                 int_clr,
   input  logic signed [K_INT+K_FRAC-1:0]       k_p,
   input  logic signed [K_INT+K_FRAC-1:0]       k_i,
   input  logic signed [K_INT+K_FRAC-1:0]       k_d,
   input  logic        [NUM_CH*DATA_W-1:0]      setpoint,
   input  logic        [NUM_CH*DATA_W-1:0]      feedback,
   output logic        [NUM_CH*OUT_W-1:0]       control_signal,
   output logic                                 out_valid,
   output logic                                 busy,
   output logic        [NUM_CH-1:0]             sat,
   output logic                                 overrun
);

   localparam int GAIN_W = K_INT + K_FRAC;
   localparam int ERR_W  = DATA_W + 1;
   localparam int DIFF_W = DATA_W + 2;
   localparam int PROD_W = GAIN_W + DIFF_W;
   localparam int SUM_W  = ACC_W + 2;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic signed [ACC_W:0]   ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0]   ACC_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
   localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_P, S_I, S_D, S_SUM} state_t;

   state_t                    r_state, w_state_next;
   logic        [CH_W-1:0]    r_ch;
   logic signed [GAIN_W-1:0]  r_kp, r_ki, r_kd;
   logic        [DATA_W-1:0]  r_sp [NUM_CH];
   logic        [DATA_W-1:0]  r_fb [NUM_CH];
   logic signed [ACC_W-1:0]   r_integ [NUM_CH];
   logic signed [ERR_W-1:0]   r_prev_e [NUM_CH];
   logic signed [OUT_W-1:0]   r_out [NUM_CH];
   logic        [NUM_CH-1:0]  r_sat, r_sat_neg;
   logic signed [PROD_W-1:0]  r_p, r_d;
   logic                      r_out_valid, r_busy, r_overrun;

   logic                      w_last, w_freeze, w_clamp;
   logic signed [ERR_W-1:0]   w_e;
   logic signed [DIFF_W-1:0]  w_diff, w_opb;
   logic signed [GAIN_W-1:0]  w_gain;
   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACC_W:0]     w_isum;
   logic signed [ACC_W-1:0]   w_integ_sat;
   logic signed [SUM_W-1:0]   w_sum, w_shift;
   logic signed [OUT_W-1:0]   w_out;

   assign w_last = (r_ch == CH_W'(NUM_CH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (sample_en) w_state_next = S_P;
         S_P:     w_state_next = S_I;
         S_I:     w_state_next = S_D;
         S_D:     w_state_next = S_SUM;
         S_SUM:   w_state_next = w_last ? S_IDLE : S_P;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath: error, operand select for the single multiplier, saturating adders.
   always_comb begin
      w_e    = $signed({1'b0, r_sp[r_ch]}) - $signed({1'b0, r_fb[r_ch]});
      w_diff = DIFF_W'(w_e) - DIFF_W'(r_prev_e[r_ch]);
      w_gain = r_kp;
      w_opb  = DIFF_W'(w_e);
      if (r_state == S_I) begin
         w_gain = r_ki;
      end else if (r_state == S_D) begin
         w_gain = r_kd;
         w_opb  = w_diff;
      end
      w_prod = PROD_W'(w_gain) * PROD_W'(w_opb);

      w_isum = (ACC_W+1)'(r_integ[r_ch]) + (ACC_W+1)'(w_prod);
      if (w_isum > ACC_MAX)      w_integ_sat = ACC_MAX[ACC_W-1:0];
      else if (w_isum < ACC_MIN) w_integ_sat = ACC_MIN[ACC_W-1:0];
      else                       w_integ_sat = w_isum[ACC_W-1:0];

      // Anti-windup: hold the integrator while it would push further into the last clamp.
      w_freeze = r_sat[r_ch] &&
                 ((!r_sat_neg[r_ch] && !w_e[ERR_W-1] && (w_e != '0)) ||
                  ( r_sat_neg[r_ch] &&  w_e[ERR_W-1]));

      w_sum   = SUM_W'(r_p) + SUM_W'(r_integ[r_ch]) + SUM_W'(r_d);
      w_shift = w_sum >>> K_FRAC;
      w_clamp = 1'b1;
      if (w_shift > OUT_MAX)      w_out = OUT_MAX[OUT_W-1:0];
      else if (w_shift < OUT_MIN) w_out = OUT_MIN[OUT_W-1:0];
      else begin
         w_out   = w_shift[OUT_W-1:0];
         w_clamp = 1'b0;
      end
   end

   // NOTE: integrators and history are architectural state, so they take the reset like any flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ch        <= '0;
         r_kp        <= '0;
         r_ki        <= '0;
         r_kd        <= '0;
         r_p         <= '0;
         r_d         <= '0;
         r_sat       <= '0;
         r_sat_neg   <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_sp[c]     <= '0;
            r_fb[c]     <= '0;
            r_integ[c]  <= '0;
            r_prev_e[c] <= '0;
            r_out[c]    <= '0;
         end
      end else begin
         r_out_valid <= 1'b0;
         if (sample_en && (r_state != S_IDLE)) r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: if (sample_en) begin
               r_ch   <= '0;
               r_busy <= 1'b1;
               r_kp   <= k_p;
               r_ki   <= k_i;
               r_kd   <= k_d;
               for (int c = 0; c < NUM_CH; c++) begin
                  r_sp[c] <= setpoint[c*DATA_W +: DATA_W];
                  r_fb[c] <= feedback[c*DATA_W +: DATA_W];
                  if (int_clr) begin
                     r_integ[c]  <= '0;
                     r_prev_e[c] <= '0;
                  end
               end
            end
            S_P: r_p <= w_prod;
            S_I: if (!w_freeze) r_integ[r_ch] <= w_integ_sat;
            S_D: begin
               r_d            <= w_prod;
               r_prev_e[r_ch] <= w_e;
            end
            S_SUM: begin
               r_out[r_ch]     <= w_out;
               r_sat[r_ch]     <= w_clamp;
               r_sat_neg[r_ch] <= w_shift[SUM_W-1];
               if (w_last) begin
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
               end else begin
                  r_ch <= r_ch + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign control_signal[g*OUT_W +: OUT_W] = r_out[g];
   end

   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign sat       = r_sat;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_pid_controller_mc.sv
// Scoreboard bench for pid_controller_mc: directed passes with hand-computed results,
// a monitor checks every out_valid against the queued expectation.
module tb_pid_controller_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_en;
   logic        int_clr;
   logic [15:0] k_p, k_i, k_d;
   logic [17:0] setpoint, feedback;
   logic [31:0] control_signal;
   logic        out_valid, busy, overrun;
   logic [1:0]  sat;

   typedef struct {
      int          cyc;
      longint      c0;
      longint      c1;
      logic [1:0]  s;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   pid_controller_mc dut (
      .clk            (clk),
      .reset          (reset),
      .sample_en      (sample_en),
      .int_clr        (int_clr),
      .k_p            (k_p),
      .k_i            (k_i),
      .k_d            (k_d),
      .setpoint       (setpoint),
      .feedback       (feedback),
      .control_signal (control_signal),
      .out_valid      (out_valid),
      .busy           (busy),
      .sat            (sat),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every completed pass is compared with the oldest expectation.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected out_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_valid cycle", cyc, e.cyc);
            check("ch0 output", $signed(control_signal[15:0]), e.c0);
            check("ch1 output", $signed(control_signal[31:16]), e.c1);
            check("sat", sat, e.s);
            check("busy low with out_valid", busy, 0);
         end
      end
   end

   // Issue one pass at the current negedge and wait (bounded) for its out_valid.
   task automatic run_pass(input logic [8:0] sp0, fb0, sp1, fb1,
                           input logic [15:0] kp, ki, kd,
                           input bit clr, input bit disturb,
                           input longint e0, e1, input logic [1:0] es);
      exp_t e;
      bit   seen;
      setpoint  = {sp1, sp0};
      feedback  = {fb1, fb0};
      k_p       = kp;
      k_i       = ki;
      k_d       = kd;
      int_clr   = clr;
      sample_en = 1'b1;
      e.cyc = cyc + 9;
      e.c0  = e0;
      e.c1  = e1;
      e.s   = es;
      sb.push_back(e);
      seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) begin
            sample_en = 1'b0;
            int_clr   = 1'b0;
            check("busy during pass", busy, 1);
         end
         if (disturb && k == 2) setpoint[8:0] = 9'd300;
         if (disturb && k == 3) sample_en = 1'b1;
         if (disturb && k == 4) begin
            sample_en = 1'b0;
            check("overrun set", overrun, 1);
         end
         if (out_valid) seen = 1'b1;
      end
      if (!seen) check("out_valid timeout", 0, 1);
   endtask

   initial begin
      reset     = 1'b1;
      sample_en = 1'b0;
      int_clr   = 1'b0;
      k_p       = '0;
      k_i       = '0;
      k_d       = '0;
      setpoint  = '0;
      feedback  = '0;
      repeat (3) @(negedge clk);
      check("reset control_signal", control_signal, 0);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset sat", sat, 0);
      check("reset overrun", overrun, 0);
      reset = 1'b0;
      @(negedge clk);

      // Proportional: 2.0 * 50 and 2.0 * -50.
      run_pass(200, 150, 100, 150, 16'h0200, 0, 0, 1, 0, 100, -100, 2'b00);

      // Integral: 0.5 * 10 accumulates 5 per pass, int_clr restarts it.
      run_pass(10, 0, 0, 0, 0, 16'h0080, 0, 1, 0, 5, 0, 2'b00);
      run_pass(10, 0, 0, 0, 0, 16'h0080, 0, 0, 0, 10, 0, 2'b00);
      run_pass(10, 0, 0, 0, 0, 16'h0080, 0, 0, 0, 15, 0, 2'b00);
      run_pass(10, 0, 0, 0, 0, 16'h0080, 0, 0, 0, 20, 0, 2'b00);
      run_pass(10, 0, 0, 0, 0, 16'h0080, 0, 1, 0, 5, 0, 2'b00);

      // Derivative: e 0->10 then 10->30.
      run_pass(10, 0, 0, 0, 0, 0, 16'h0100, 1, 0, 10, 0, 2'b00);
      run_pass(30, 0, 0, 0, 0, 0, 16'h0100, 0, 0, 20, 0, 2'b00);

      // Positive saturation; integrator must stay at 511*256 after the first pass.
      run_pass(511, 0, 0, 0, 16'h7F00, 16'h0100, 0, 1, 0, 32767, 0, 2'b01);
      for (int i = 0; i < 4; i++)
         run_pass(511, 0, 0, 0, 16'h7F00, 16'h0100, 0, 0, 0, 32767, 0, 2'b01);
      run_pass(0, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 511, 0, 2'b00);

      // Negative mirror: integrator goes back to 0 then freezes there.
      run_pass(0, 511, 0, 0, 16'h7F00, 16'h0100, 0, 0, 0, -32768, 0, 2'b01);
      run_pass(0, 511, 0, 0, 16'h7F00, 16'h0100, 0, 0, 0, -32768, 0, 2'b01);
      run_pass(0, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 0, 0, 2'b00);

      // Overrun and capture: setpoint changed mid-pass and a stray sample_en.
      check("overrun clear before", overrun, 0);
      run_pass(100, 0, 0, 20, 16'h0100, 0, 0, 1, 1, 100, -20, 2'b00);
      check("overrun sticky", overrun, 1);

      // Reset mid-pass after building integrator state.
      run_pass(10, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 10, 0, 2'b00);
      setpoint  = {9'd0, 9'd10};
      feedback  = '0;
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
      repeat (4) @(negedge clk);
      check("ch0 before mid-pass reset", $signed(control_signal[15:0]), 20);
      check("busy before mid-pass reset", busy, 1);
      reset = 1'b1;
      #1;
      check("mid reset control_signal", control_signal, 0);
      check("mid reset busy", busy, 0);
      check("mid reset out_valid", out_valid, 0);
      check("mid reset sat", sat, 0);
      check("mid reset overrun", overrun, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_pass(10, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 10, 0, 2'b00);

      repeat (3) @(negedge clk);
      check("scoreboard drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pid_controller_mc.md
# pid_controller_mc

Multi-channel, time-multiplexed fixed-point PID controller for the wall-follower control loop. One sample strobe starts a pass that computes P, I and D terms for `NUM_CH` independent channels, such as left/right wheel or distance loops. A single shared multiplier serves all terms and channels. The integrator has anti-windup, each output saturates, and a one-cycle `out_valid` marks a completed pass. It sits between the sensor front-end (setpoint/feedback) and the motor PWM generators.

## Interface
- `NUM_CH`, 2: number of channels (≥1).
- `DATA_W`, 9: setpoint/feedback width, unsigned.
- `K_INT`, 8: integer bits of each gain, sign bit included.
- `K_FRAC`, 8: fractional bits of each gain.
- `ACC_W`, 32: integrator width, signed, same scaling as the product (K_FRAC fractional bits).
- `OUT_W`, 16: per-channel control output width, signed.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `sample_en`  in  1  start-pass strobe (typically the 100 Hz clock enable).
- `int_clr`  in  1  with an accepted `sample_en`, zero all integrators and prev_errors before the pass.
- `k_p`, `k_i`, `k_d`  in  K_INT+K_FRAC each  signed two's-complement gains, shared by all channels.
- `setpoint`  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
- `feedback`  in  NUM_CH*DATA_W  same packing as `setpoint`.
- `control_signal`  out  NUM_CH*OUT_W  signed outputs, channel c at [c*OUT_W +: OUT_W].
- `out_valid`  out  1  one-cycle pulse when a pass completes.
- `busy`  out  1  pass in progress.
- `sat`  out  NUM_CH  channel c output clamped on its last update.
- `overrun`  out  1  sticky: `sample_en` arrived while busy.

## Operation
- **FSM states:** IDLE, P, I, D, SUM.
  - IDLE → P on `sample_en`. P → I → D → SUM for channel c.
  - SUM → P with c+1, or → IDLE after the last channel.
- **Capture:** on acceptance, latch the gains, all setpoints/feedbacks and `int_clr`. Later input changes do not affect the pass.
- **Error:** e = zero-extended setpoint − zero-extended feedback, signed DATA_W+1 bits.
- **P cycle:** P = k_p·e, full-precision signed product.
- **I cycle:** integ_c += k_i·e, saturating at ±(2^(ACC_W−1)−1).
  - Freeze integ_c (anti-windup) when sat_c was set by the previous pass and sign(e) equals the sign of that clamp.
  - e = 0 adds 0.
- **D cycle:**
  - D = k_d·(e − prev_e_c); the difference is DATA_W+2 bits.
  - prev_e_c ← e.
  - After reset or `int_clr`, prev_e_c = 0.
- **SUM cycle:**
  - s = P + integ_c + D, computed in ACC_W+2 bits.
  - Arithmetic shift right by K_FRAC (floor).
  - Clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. Write `control_signal[c]` and set `sat[c]` if clamped.
- **Multiplier:** exactly one, shared. Operands are selected by state.
- **Overrun:** `sample_en` while busy is ignored and sets `overrun`. Only reset clears it.
- **Reset:** `reset` at any time, including mid-pass, forces:
  - all outputs to 0: `control_signal`, `out_valid`, `busy`, `sat`, `overrun`;
  - integrators and prev_errors to 0;
  - FSM to IDLE.

## Timing
- `sample_en` is accepted at edge 0. Channel c occupies cycles 4c+1 … 4c+4.
- `control_signal[c]` and `sat[c]` update at the end of cycle 4c+4. Other channels hold their values.
- `busy` is high in cycles 1 … 4·NUM_CH.
- `out_valid` is high in cycle 4·NUM_CH+1, with `busy` low. A new `sample_en` is accepted in that cycle.
- Pass latency is 4·NUM_CH+1 cycles (9 for NUM_CH=2). Minimum sample period is 4·NUM_CH+1 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
All scenarios use NUM_CH=2, DATA_W=9, Q8.8 gains, OUT_W=16.
1. **Proportional:** k_p=0x0200, k_i=k_d=0; ch0 sp=200/fb=150, ch1 sp=100/fb=150 → ch0=100, ch1=−100, `out_valid` exactly at cycle 9, sat=0.
2. **Integral:** k_i=0x0080, k_p=k_d=0, e=10 on ch0 for 4 passes → ch0 outputs 5, 10, 15, 20. A pass with `int_clr` → ch0 output 5.
3. **Derivative:** k_d=0x0100, other gains 0, ch0 e=10 then e=30 → outputs 10, then 20.
4. **Saturation and anti-windup:**
   - k_p=0x7F00, k_i=0x0100, ch0 sp=511/fb=0 → ch0=32767, sat[0]=1.
   - Repeat 5 passes, then k_p=0 and e=0 → ch0=511, showing the integrator froze after the first pass.
   - Negative mirror case → −32768.
5. **Overrun and capture:**
   - `sample_en` at cycle 3 → ignored, overrun=1, `out_valid` still at cycle 9.
   - Change setpoint at cycle 2 → result uses the captured value.
6. **Reset mid-pass:** assert `reset` at cycle 5 after a nonzero pass → all outputs 0 and busy=0 immediately. The next pass with e=10, k_i=0x0100 gives 10, proving the integrator was cleared.
